// File: rtl/bf_io_pkg.sv
// Shared definitions for the byte-stream I/O endpoint: FSM encoding and the
// CPU direction constants.
package bf_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  // Must match the encoding the CPU core drives on io_dir.
  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

endpackage

// File: rtl/bf_byte_fifo.sv
// Byte FIFO of 2^DEPTH_LOG2 entries with explicit count; push/pop are ignored
// when full/empty at the start of the cycle (no bypass).
module bf_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int W     = DEPTH_LOG2 + 1;

  logic [7:0]   mem [DEPTH];
  logic [W-1:0] rd_ptr, wr_ptr, count;
  logic         do_push, do_pop;

  assign full    = (count == W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Contents are deliberately left unreset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == W'(DEPTH - 1)) ? '0 : wr_ptr + W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == W'(DEPTH - 1)) ? '0 : rd_ptr + W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + W'(1);
        2'b01:   count <= count - W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bf_io_port.sv
// CPU io_req/io_ack endpoint bridging to TX/RX byte streams through FIFOs.
// Optional macro BF_IO_RX_BLOCK_EN: reads of an empty RX FIFO stall instead of returning 0.
module bf_io_port
  import bf_io_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_req,
  input  logic       io_dir,
  input  logic [7:0] io_wdata,
  output logic       io_ack,
  output logic [7:0] io_rdata,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready
);

`ifdef BF_IO_RX_BLOCK_EN
  localparam bit RX_BLOCK = 1'b1;
`else
  localparam bit RX_BLOCK = 1'b0;
`endif

  state_t     state, state_nxt;
  logic       tx_push, tx_full, tx_empty;
  logic       rx_pop, rx_full, rx_empty;
  logic       rdata_clr;
  logic [7:0] rx_dout;

  bf_byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (io_wdata),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  bf_byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (io_req) begin
          if (io_dir == DIRECTION_WRITE)
            state_nxt = tx_full ? ST_WR_WAIT : ST_ACK;
          else
            state_nxt = (rx_empty && RX_BLOCK) ? ST_RD_WAIT : ST_ACK;
        end
      end
      ST_WR_WAIT: if (!tx_full)  state_nxt = ST_ACK;
      ST_RD_WAIT: if (!rx_empty) state_nxt = ST_ACK;
      ST_ACK:     if (!io_req)   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Push/pop fire only on the edge that leaves IDLE or a wait state, so a
  // long handshake still moves exactly one byte.
  always_comb begin
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    rdata_clr = 1'b0;
    io_ack    = (state == ST_ACK);
    unique case (state)
      ST_IDLE: begin
        if (io_req) begin
          if (io_dir == DIRECTION_WRITE) tx_push = !tx_full;
          else if (!rx_empty)            rx_pop  = 1'b1;
          else                           rdata_clr = !RX_BLOCK;
        end
      end
      ST_WR_WAIT: tx_push = !tx_full;
      ST_RD_WAIT: rx_pop  = !rx_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         io_rdata <= '0;
    else if (rx_pop)    io_rdata <= rx_dout;
    else if (rdata_clr) io_rdata <= '0;
  end

endmodule

// File: tb/tb_bf_io_port.sv
// Directed bench for bf_io_port: cycle table plus hand sequences for FIFO-full,
// long handshake and mid-transaction reset.
module tb_bf_io_port;
  import bf_io_pkg::*;

  logic       clk, rst_n;
  logic       io_req, io_dir;
  logic [7:0] io_wdata;
  logic       io_ack;
  logic [7:0] io_rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  int total = 0;
  int bad   = 0;

  bf_io_port #(.FIFO_DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_req   (io_req),
    .io_dir   (io_dir),
    .io_wdata (io_wdata),
    .io_ack   (io_ack),
    .io_rdata (io_rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req, dir;
    logic [7:0] wdata;
    logic       txr, rxv;
    logic [7:0] rxd;
    logic       ack;
    logic [7:0] rdata;
    logic       txv;
    logic [7:0] txd;
    logic       rxr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic dir, input logic [7:0] wdata,
                     input logic txr, input logic rxv, input logic [7:0] rxd,
                     input logic ack, input logic [7:0] rdata, input logic txv,
                     input logic [7:0] txd);
    vec_t v;
    v = '{req, dir, wdata, txr, rxv, rxd, ack, rdata, txv, txd, 1'b1};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge, returns at the negedge after io_ack falls.
  task automatic cpu_write(input logic [7:0] d, input int lat, input string nm);
    int n;
    n = 0;
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = d;
    do begin @(negedge clk); n++; end while (!io_ack && n < 20);
    chk({nm, "_lat"}, n, lat);
    io_req = 1'b0;
    @(negedge clk);
    chk({nm, "_ackfall"}, io_ack, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; io_req = 1'b0; io_dir = 1'b0; io_wdata = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;

    @(negedge clk);
    chk("rst_ack", io_ack, 0);
    chk("rst_rdata", io_rdata, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_rxr", rx_ready, 1);
    rst_n = 1'b1;

    //   req dir wdata txr rxv rxd    ack rdata  txv txd
    add(0, 0, 8'h00, 1, 0, 8'h00,   0, 8'h00,  0, 8'h00);
    add(1, 1, 8'h41, 1, 0, 8'h00,   1, 8'h00,  1, 8'h41);
    add(0, 1, 8'h41, 1, 0, 8'h00,   0, 8'h00,  0, 8'h00);
    add(0, 0, 8'h00, 1, 0, 8'h00,   0, 8'h00,  0, 8'h00);
    add(0, 0, 8'h00, 0, 1, 8'h7A,   0, 8'h00,  0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 8'h00,   1, 8'h7A,  0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h7A,  0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h7A,  0, 8'h00);
`ifdef BF_IO_RX_BLOCK_EN
    add(1, 0, 8'h00, 0, 0, 8'h00,   0, 8'h7A,  0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 8'h00,   0, 8'h7A,  0, 8'h00);
    add(1, 0, 8'h00, 0, 1, 8'h33,   0, 8'h7A,  0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 8'h00,   1, 8'h33,  0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h33,  0, 8'h00);
`else
    add(1, 0, 8'h00, 0, 0, 8'h00,   1, 8'h00,  0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h00,  0, 8'h00);
    add(0, 0, 8'h00, 0, 1, 8'h33,   0, 8'h00,  0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 8'h00,   1, 8'h33,  0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h33,  0, 8'h00);
    // FIFO drained by the previous read: must see the zero path again.
    add(1, 0, 8'h00, 0, 0, 8'h00,   1, 8'h00,  0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h00,  0, 8'h00);
`endif

    foreach (vecs[i]) begin
      io_req = vecs[i].req; io_dir = vecs[i].dir; io_wdata = vecs[i].wdata;
      tx_ready = vecs[i].txr; rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), io_ack, vecs[i].ack);
      chk($sformatf("v%0d_rdata", i), io_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_txv", i), tx_valid, vecs[i].txv);
      chk($sformatf("v%0d_rxr", i), rx_ready, vecs[i].rxr);
      if (vecs[i].txv) chk($sformatf("v%0d_txd", i), tx_data, vecs[i].txd);
    end
    io_req = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;

    // TX full: 16 writes ack immediately, the 17th waits for one drained beat.
    for (int i = 0; i < 16; i++) cpu_write(8'(i), 1, $sformatf("fill%0d", i));
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'd16;
    repeat (3) begin
      @(negedge clk);
      chk("wrwait_ack", io_ack, 0);
    end
    chk("full_head", tx_data, 8'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("pulse_ack", io_ack, 0);
    chk("pulse_head", tx_data, 8'd1);
    tx_ready = 1'b0;
    @(negedge clk);
    chk("wrwait_done", io_ack, 1);
    io_req = 1'b0;
    @(negedge clk);
    chk("wrwait_fall", io_ack, 0);
    tx_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain%0d_v", k), tx_valid, 1);
      chk($sformatf("drain%0d_d", k), tx_data, 8'(k));
      @(negedge clk);
    end
    chk("drain_empty", tx_valid, 0);
    tx_ready = 1'b0;

    // Long handshake: request held 5 cycles past ack moves one byte.
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h5C;
    @(negedge clk);
    chk("hold_ack", io_ack, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_ack_held", io_ack, 1);
    end
    io_req = 1'b0;
    @(negedge clk);
    chk("hold_fall", io_ack, 0);
    chk("hold_txv", tx_valid, 1);
    chk("hold_txd", tx_data, 8'h5C);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("hold_single", tx_valid, 0);
    tx_ready = 1'b0;

    // Fill RX, park a write in WR_WAIT, then reset asynchronously.
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h80 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("rx_full", rx_ready, 0);
    for (int i = 0; i < 16; i++) cpu_write(8'(i), 1, $sformatf("refill%0d", i));
    io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'hEE;
    repeat (2) @(negedge clk);
    chk("pre_rst_ack", io_ack, 0);
    chk("pre_rst_txv", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ack", io_ack, 0);
    chk("arst_txv", tx_valid, 0);
    chk("arst_rxr", rx_ready, 1);
    chk("arst_rdata", io_rdata, 0);
    @(negedge clk);
    io_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", io_ack, 0);
    chk("post_rst_txv", tx_valid, 0);
    cpu_write(8'hA5, 1, "post_rst");
    chk("post_rst_txd", tx_data, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_io_port.md
# bf_io_port

Byte-stream I/O endpoint that terminates the CPU core's `io_req`/`io_dir`/`io_ack` handshake. It sits directly downstream of the CPU's I/O port. Output-instruction bytes go into a TX FIFO drained by a valid/ready stream. Input-instruction bytes are taken from an RX FIFO filled by a valid/ready stream. Both FIFOs decouple the single-byte CPU handshake from the external console or host link.

## Interface
Parameters:
- `FIFO_DEPTH_LOG2`, default 4: each FIFO holds 2^N bytes (N ≥ 1).

Ports:
- `clk`  in  1  — single clock, all state on posedge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `io_req`  in  1  — CPU request, level, held until ack seen.
- `io_dir`  in  1  — `DIRECTION_READ` (0) or `DIRECTION_WRITE` (1); valid while `io_req`.
- `io_wdata`  in  8  — byte to output; valid while `io_req` and write.
- `io_ack`  out  1  — completion, 4-phase.
- `io_rdata`  out  8  — input byte; valid while `io_ack` on a read.
- `tx_valid`  out  1  — TX FIFO non-empty.
- `tx_data`  out  8  — head of TX FIFO.
- `tx_ready`  in  1  — sink accepts byte when `tx_valid && tx_ready`.
- `rx_valid`  in  1  — source offers byte.
- `rx_data`  in  8  — offered byte.
- `rx_ready`  out  1  — RX FIFO not full.

## Operation
FSM states:
- IDLE: no request is being serviced.
  - `io_req` and write, TX not full: push `io_wdata`, go to ACK.
  - `io_req` and write, TX full: go to WR_WAIT.
  - `io_req` and read, RX not empty: pop into `io_rdata`, go to ACK.
  - `io_req` and read, RX empty: go to RD_WAIT (behaviour per Configuration).
- WR_WAIT: when TX not full, push `io_wdata` and go to ACK.
- RD_WAIT: when RX not empty, pop and go to ACK.
- ACK: `io_ack` is 1. Hold it until `io_req` is sampled 0, then go to IDLE with `io_ack` 0.

Handshake and data rules:
- Exactly one push or pop per CPU transaction, whatever the length of the handshake.
- `io_rdata` holds the last popped byte until the next read completes.

FIFOs:
- Each FIFO uses a read pointer, a write pointer and a count, all of width `FIFO_DEPTH_LOG2+1`. Pointers wrap modulo depth.
- Full means count == depth. Empty means count == 0.
- A push is accepted only if not full at the start of the cycle; a pop only if not empty. There is no bypass.
- A simultaneous push and pop leaves the count unchanged.
- `tx_valid` = !tx_empty. `tx_data` = mem[rd_ptr]. `rx_ready` = !rx_full.
- A stream beat transfers on a posedge with valid && ready. An `rx_valid` beat while full is not accepted; the source must hold it.

Reset (asserted asynchronously, any state):
- State = IDLE.
- Pointers and counts = 0.
- `io_ack` = 0, `io_rdata` = 0, `tx_valid` = 0.
- `rx_ready` = 1 after reset.
- FIFO contents are not reset and are discarded.
- Reset in the middle of a transaction drops it; the CPU is reset alongside.

## Timing
- `io_req` is sampled at posedge. Best-case latency from the edge that samples `io_req` high to `io_ack` high: 1 edge (registered at that same edge). The push or pop commits at that same edge.
- `io_ack` falls on the first posedge at which `io_req` is 0.
- A new request is recognised no earlier than the posedge after `io_ack` falls, so at least 1 idle cycle between transactions.
- A TX push becomes visible on `tx_valid` 1 cycle later.
- An RX stream byte accepted at edge k can be popped by a CPU read at edge k+1.
- The CPU drives its handshake outputs on negedge, so all inputs are stable at posedge and no synchroniser is required.

## Configuration
`BF_IO_RX_BLOCK_EN`:
- Defined: a read of an empty RX FIFO stalls in RD_WAIT, `io_ack` held low, until a byte arrives.
- Undefined: a read of an empty RX FIFO completes immediately from IDLE. `io_rdata` = 8'h00 (EOF-as-zero convention), nothing is popped, and RD_WAIT is unreachable.

## Structure
- Shared package `bf_io_pkg`: FSM state encoding (IDLE, WR_WAIT, RD_WAIT, ACK) and the `DIRECTION_READ`/`DIRECTION_WRITE` constants. The direction constants are identical to those the CPU uses.
- Sub-module `bf_byte_fifo` (parameter `DEPTH_LOG2`; ports push, pop, din, dout, full, empty), instantiated twice for TX and RX.

## Test plan
- Write 8'h41 with `tx_ready`=1 → `io_ack` rises 1 edge after `io_req` is sampled; `tx_valid`=1 with `tx_data`=8'h41 on the next cycle, then empty.
- Preload RX with 8'h7A, then read → `io_rdata`=8'h7A while `io_ack`=1; `rx_ready` stays 1; a second read hits the empty-FIFO path.
- With `tx_ready`=0, do 16 writes (N=4) → all acked. On the 17th write `io_ack` stays 0 (WR_WAIT). Pulse `tx_ready` for 1 beat → ack follows, and FIFO order is 0..16 preserved.
- Read of empty RX: with `BF_IO_RX_BLOCK_EN` → ack waits until `rx_valid` presents 8'h33 and then returns 8'h33; without it → immediate ack with 8'h00 and the count stays 0.
- Hold `io_req` high for 5 cycles after ack → exactly one push; `io_ack` drops the edge after `io_req` falls.
- Assert `rst_n`=0 while in WR_WAIT → `io_ack`=0, `tx_valid`=0, `rx_ready`=1 immediately; IDLE after release.
